// File: rtl/brush_stamper.sv
// brush_stamper: turns the cursor snapshot into a clipped square brush of
// frame-buffer writes, one candidate pixel per unstalled cycle, row-major.
// Each distinct pen-down snapshot {x, y, colour, width} is stamped once.

module brush_stamper #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int COLOR_W  = 4,
    parameter int ADDR_W   = 19
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               draw_in,
    input  logic [9:0]         cursor_loc_x,
    input  logic [8:0]         cursor_loc_y,
    input  logic [COLOR_W-1:0] cursor_color,
    input  logic [2:0]         stroke_width,
    input  logic               wr_ready_in,
    output logic               wr_valid_out,
    output logic [ADDR_W-1:0]  wr_addr_out,
    output logic [COLOR_W-1:0] wr_data_out,
    output logic               busy_out,
    output logic               stamp_done_out
);

    typedef enum logic {
        IDLE,
        STAMP
    } state_t;

    state_t              r_state;

    // Latched snapshot; doubles as the last-stamp record while r_recValid is set.
    logic [9:0]          r_x;
    logic [8:0]          r_y;
    logic [COLOR_W-1:0]  r_color;
    logic [2:0]          r_w;
    logic                r_recValid;

    // Iterator holds the next candidate offset; r_allIssued marks that the
    // final candidate has already been presented or skipped.
    logic signed [3:0]   r_dx;
    logic signed [3:0]   r_dy;
    logic                r_allIssued;

    logic                r_valid;
    logic [ADDR_W-1:0]   r_addr;
    logic [COLOR_W-1:0]  r_data;
    logic                r_busy;
    logic                r_done;

    logic                w_inIdle;
    logic [9:0]          w_curX;
    logic [8:0]          w_curY;
    logic signed [3:0]   w_wS;
    logic signed [3:0]   w_negW;
    logic signed [3:0]   w_candDx;
    logic signed [3:0]   w_candDy;
    logic signed [10:0]  w_px;
    logic signed [10:0]  w_py;
    logic                w_inBounds;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_isLast;
    logic signed [3:0]   w_nextDx;
    logic signed [3:0]   w_nextDy;
    logic                w_snapChanged;
    logic                w_stall;

    // In IDLE the first candidate comes straight from the live cursor so the
    // first write is presented on the acceptance edge; in STAMP it comes from
    // the latched snapshot and iterator.
    assign w_inIdle   = (r_state == IDLE);
    assign w_curX     = w_inIdle ? cursor_loc_x : r_x;
    assign w_curY     = w_inIdle ? cursor_loc_y : r_y;
    assign w_wS       = $signed({1'b0, (w_inIdle ? stroke_width : r_w)});
    assign w_negW     = -w_wS;
    assign w_candDx   = w_inIdle ? w_negW : r_dx;
    assign w_candDy   = w_inIdle ? w_negW : r_dy;

    assign w_px       = $signed({1'b0, w_curX}) + $signed({{7{w_candDx[3]}}, w_candDx});
    assign w_py       = $signed({2'b00, w_curY}) + $signed({{7{w_candDy[3]}}, w_candDy});

    assign w_inBounds = !w_px[10] && !w_py[10]
                        && (int'(w_px) < H_ACTIVE) && (int'(w_py) < V_ACTIVE);
    assign w_addr     = ADDR_W'(w_py[9:0]) * ADDR_W'(H_ACTIVE) + ADDR_W'(w_px[9:0]);

    assign w_isLast   = (w_candDx == w_wS) && (w_candDy == w_wS);
    assign w_nextDx   = (w_candDx == w_wS) ? w_negW : w_candDx + 4'sd1;
    assign w_nextDy   = (w_candDx == w_wS) ? w_candDy + 4'sd1 : w_candDy;

    assign w_snapChanged = !r_recValid
                           || ({cursor_loc_x, cursor_loc_y, cursor_color, stroke_width}
                               != {r_x, r_y, r_color, r_w});
    assign w_stall    = r_valid && !wr_ready_in;

    // Stamp FSM: accept a new snapshot, walk the brush square, hold on back-pressure.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state     <= IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_color     <= '0;
            r_w         <= '0;
            r_recValid  <= 1'b0;
            r_dx        <= '0;
            r_dy        <= '0;
            r_allIssued <= 1'b0;
            r_valid     <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!draw_in) begin
                        r_recValid <= 1'b0;
                    end else if (w_snapChanged) begin
                        r_x         <= cursor_loc_x;
                        r_y         <= cursor_loc_y;
                        r_color     <= cursor_color;
                        r_w         <= stroke_width;
                        r_recValid  <= 1'b1;
                        r_valid     <= w_inBounds;
                        r_addr      <= w_addr;
                        r_data      <= cursor_color;
                        r_dx        <= w_nextDx;
                        r_dy        <= w_nextDy;
                        r_allIssued <= w_isLast;
                        r_busy      <= 1'b1;
                        r_state     <= STAMP;
                    end
                end
                STAMP: begin
                    if (!w_stall) begin
                        if (r_allIssued) begin
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_valid     <= w_inBounds;
                            r_addr      <= w_addr;
                            r_dx        <= w_nextDx;
                            r_dy        <= w_nextDy;
                            r_allIssued <= w_isLast;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign wr_valid_out   = r_valid;
    assign wr_addr_out    = r_addr;
    assign wr_data_out    = r_data;
    assign busy_out       = r_busy;
    assign stamp_done_out = r_done;

endmodule

// File: tb/tb_brush_stamper.sv
// tb_brush_stamper: directed and randomized brush stamps checked against a
// loop-based reference model of the clipped square brush.

module tb_brush_stamper;

    localparam int H_ACT = 640;
    localparam int V_ACT = 480;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        draw_in;
    logic [9:0]  cursor_loc_x;
    logic [8:0]  cursor_loc_y;
    logic [3:0]  cursor_color;
    logic [2:0]  stroke_width;
    logic        wr_ready_in;
    logic        wr_valid_out;
    logic [18:0] wr_addr_out;
    logic [3:0]  wr_data_out;
    logic        busy_out;
    logic        stamp_done_out;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    int expQ[$];
    int gotQ[$];

    brush_stamper #(
        .H_ACTIVE(H_ACT),
        .V_ACTIVE(V_ACT),
        .COLOR_W(4),
        .ADDR_W(19)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .draw_in(draw_in),
        .cursor_loc_x(cursor_loc_x),
        .cursor_loc_y(cursor_loc_y),
        .cursor_color(cursor_color),
        .stroke_width(stroke_width),
        .wr_ready_in(wr_ready_in),
        .wr_valid_out(wr_valid_out),
        .wr_addr_out(wr_addr_out),
        .wr_data_out(wr_data_out),
        .busy_out(busy_out),
        .stamp_done_out(stamp_done_out)
    );

    // Free-running clock.
    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic checkOutput(input string tag, input integer observed, input integer expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Reference brush: every pixel of the (2w+1)^2 square in row-major order,
    // dropping those that fall outside the canvas.
    task automatic buildModel(input int x, input int y, input int w);
        expQ.delete();
        for (int dy = -w; dy <= w; dy++) begin
            for (int dx = -w; dx <= w; dx++) begin
                if (x + dx >= 0 && x + dx < H_ACT && y + dy >= 0 && y + dy < V_ACT)
                    expQ.push_back((y + dy) * H_ACT + (x + dx));
            end
        end
    endtask

    task automatic penUp();
        draw_in = 1'b0;
        tick();
    endtask

    // mode 0: always ready; mode 1: stall stallLen cycles on write stallIdx;
    // mode 2: random ready.
    task automatic applyStimulus(input int x, input int y, input int color, input int w,
                                 input int mode, input int stallIdx, input int stallLen,
                                 input bit moveMid, input int holdAfter);
        int  busyCycles   = 0;
        int  stalled      = 0;
        int  stallUsed    = 0;
        bit  doneSeen     = 0;
        bit  prevStall    = 0;
        bit  moved        = 0;
        int  prevAddr     = 0;
        int  side         = 2 * w + 1;
        int  cmpLen;
        buildModel(x, y, w);
        gotQ.delete();
        cursor_loc_x = 10'(x);
        cursor_loc_y = 9'(y);
        cursor_color = 4'(color);
        stroke_width = 3'(w);
        draw_in      = 1'b1;
        wr_ready_in  = 1'b1;
        for (int cyc = 0; cyc < 600 && !doneSeen; cyc++) begin
            tick();
            if (prevStall) begin
                checkOutput("holdValid", 32'(wr_valid_out), 1);
                checkOutput("holdAddr", 32'(wr_addr_out), prevAddr);
                checkOutput("holdData", 32'(wr_data_out), color);
            end
            if (stamp_done_out) begin
                doneSeen = 1;
                checkOutput("doneBusyLow", 32'(busy_out), 0);
                checkOutput("doneValidLow", 32'(wr_valid_out), 0);
            end else begin
                if (busy_out) busyCycles++;
                case (mode)
                    1: begin
                        if (wr_valid_out && gotQ.size() == stallIdx && stallUsed < stallLen) begin
                            wr_ready_in = 1'b0;
                            stallUsed++;
                        end else begin
                            wr_ready_in = 1'b1;
                        end
                    end
                    2: wr_ready_in = ($urandom_range(0, 3) != 0);
                    default: wr_ready_in = 1'b1;
                endcase
                prevStall = wr_valid_out && !wr_ready_in;
                if (prevStall) begin
                    stalled++;
                    prevAddr = 32'(wr_addr_out);
                end
                if (wr_valid_out && wr_ready_in) begin
                    gotQ.push_back(32'(wr_addr_out));
                    checkOutput("wrData", 32'(wr_data_out), color);
                end
                if (moveMid && !moved && gotQ.size() == 1) begin
                    cursor_loc_x = 10'(x + 37);
                    cursor_loc_y = 9'(y + 11);
                    cursor_color = 4'(color + 1);
                    moved = 1;
                end
            end
        end
        checkOutput("doneSeen", 32'(doneSeen), 1);
        checkOutput("writeCount", gotQ.size(), expQ.size());
        cmpLen = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
        for (int i = 0; i < cmpLen; i++)
            checkOutput("wrAddr", gotQ[i], expQ[i]);
        checkOutput("busyCycles", busyCycles, side * side + stalled);
        wr_ready_in = 1'b1;
        for (int i = 0; i < holdAfter; i++) begin
            tick();
            checkOutput("holdNoWrite", 32'(wr_valid_out), 0);
            checkOutput("holdNotBusy", 32'(busy_out), 0);
        end
        penUp();
    endtask

    initial begin
        int  xfers;
        bit  found;
        $display("[TB] brush_stamper bench starting");
        rst_in       = 1'b1;
        draw_in      = 1'b0;
        cursor_loc_x = '0;
        cursor_loc_y = '0;
        cursor_color = '0;
        stroke_width = '0;
        wr_ready_in  = 1'b1;

        // Reset state and idle with pen up.
        tick();
        tick();
        checkOutput("rstValid", 32'(wr_valid_out), 0);
        checkOutput("rstAddr", 32'(wr_addr_out), 0);
        checkOutput("rstData", 32'(wr_data_out), 0);
        checkOutput("rstBusy", 32'(busy_out), 0);
        checkOutput("rstDone", 32'(stamp_done_out), 0);
        rst_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("idleValid", 32'(wr_valid_out), 0);
            checkOutput("idleBusy", 32'(busy_out), 0);
        end

        // Single-pixel brush, then hold the same snapshot.
        applyStimulus(100, 50, 5, 0, 0, 0, 0, 1'b0, 20);
        checkOutput("singleAddr", (gotQ.size() > 0) ? gotQ[0] : -1, 32100);

        // Corner clip at the origin.
        applyStimulus(0, 0, 3, 1, 0, 0, 0, 1'b0, 0);

        // Opposite corner, then re-stamp after pen-up.
        applyStimulus(639, 479, 7, 2, 0, 0, 0, 1'b0, 0);
        checkOutput("lastAddr", (gotQ.size() > 0) ? gotQ[gotQ.size() - 1] : -1, 307199);
        applyStimulus(639, 479, 7, 2, 0, 0, 0, 1'b0, 0);

        // Back-pressure on the 4th write plus cursor moving mid-stamp.
        applyStimulus(320, 240, 10, 1, 1, 3, 3, 1'b1, 0);

        // Fully clipped stamp still completes.
        applyStimulus(1000, 500, 2, 2, 0, 0, 0, 1'b0, 0);

        // Reset during the 5th write of a w=3 stamp.
        cursor_loc_x = 10'd320;
        cursor_loc_y = 9'd240;
        cursor_color = 4'd9;
        stroke_width = 3'd3;
        draw_in      = 1'b1;
        wr_ready_in  = 1'b1;
        xfers = 0;
        found = 0;
        for (int cyc = 0; cyc < 100 && !found; cyc++) begin
            tick();
            if (wr_valid_out) begin
                if (xfers == 4) found = 1;
                else xfers++;
            end
        end
        checkOutput("reachFifthWrite", 32'(found), 1);
        rst_in = 1'b1;
        tick();
        checkOutput("midRstValid", 32'(wr_valid_out), 0);
        checkOutput("midRstBusy", 32'(busy_out), 0);
        rst_in = 1'b0;
        applyStimulus(320, 240, 9, 3, 0, 0, 0, 1'b0, 0);

        // Randomized stamps with random back-pressure.
        for (int n = 0; n < 8; n++) begin
            applyStimulus($urandom_range(0, 700), $urandom_range(0, 500),
                          $urandom_range(0, 15), $urandom_range(0, 7),
                          2, 0, 0, 1'b0, 0);
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
